rr_grant_sched64: RTL and testbench

- Round-robin scheduler that shares one 6-to-64 one-hot select resource among 64 requesters.
- Registers a 6-bit grant index and drives it through the 6-to-64 decoder to produce the one-hot grant vector.
- Sits between the requester bank and the decoded select lines; it is the only block that sequences the decoder input.

---
 rtl/rr_grant_sched64_pkg.sv | 17 +
 rtl/rr_grant_sched64_dec6to64.sv | 21 ++
 rtl/rr_grant_sched64.sv | 142 ++++++++++++++
 tb/tb_rr_grant_sched64.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_sched64_pkg.sv
// rr_grant_sched64_pkg: shared sizes and FSM encoding for the round-robin grant scheduler.
`default_nettype none

package rr_grant_sched64_pkg;

  localparam int N_REQ            = 64;
  localparam int IDX_W            = 6;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage : rr_grant_sched64_pkg

`default_nettype wire

// File: rtl/rr_grant_sched64_dec6to64.sv
// dec6to64: 6-bit index to 64-bit one-hot decoder; output forced to zero when en_i is low.
`default_nettype none

module dec6to64
  import rr_grant_sched64_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule : dec6to64

`default_nettype wire

// File: rtl/rr_grant_sched64.sv
// rr_grant_sched64: 64-way round-robin scheduler driving a shared 6-to-64 one-hot select.
// Optional per-grant hold limit enabled by defining HOLD_LIMIT_EN.
`default_nettype none

module rr_grant_sched64
  import rr_grant_sched64_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot
);

  // Returns {found, index} of the first set bit at or above start, wrapping 63->0.
  function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] res;
    logic             found;
    found = 1'b0;
    res   = start;
    for (int i = 0; i < N_REQ; i++) begin
      pos = start + IDX_W'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        res   = pos;
      end
    end
    return {found, res};
  endfunction

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [N_REQ-1:0] cand;
  logic [IDX_W:0]   srch;
  logic             rel;
  logic             force_rel;

`ifdef HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign force_rel = (state_q == GRANT) && req[idx_q] &&
                     (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  // A fresh grant (first grant or any regrant, even to the same index) restarts the count.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_d == GRANT) && ((state_q == IDLE) || rel)) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (MAX_HOLD > 0) && (HOLD_W > 0);
  assign force_rel       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    last_ptr_d = last_ptr_q;
    cand       = req;
    srch       = '0;
    rel        = 1'b0;
    case (state_q)
      IDLE: begin
        srch = rr_search(req, last_ptr_q + 1'b1);
        if (arb_en && (|req)) begin
          idx_d   = srch[IDX_W-1:0];
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rel = !req[idx_q] || force_rel;
        if (rel) begin
          last_ptr_d  = idx_q;
          cand[idx_q] = 1'b0;
          srch        = rr_search(cand, idx_q + 1'b1);
          if (arb_en && srch[IDX_W]) begin
            idx_d = srch[IDX_W-1:0];
          end else if (arb_en && force_rel) begin
            // Lone requester cut off by the hold limit is simply granted again.
            idx_d = idx_q;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

  dec6to64 u_dec (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (grant_onehot)
  );

endmodule : rr_grant_sched64

`default_nettype wire

// File: tb/tb_rr_grant_sched64.sv
// tb_rr_grant_sched64: directed and randomized checks of rr_grant_sched64 against a rotation model.
`default_nettype none

module tb_rr_grant_sched64;

  localparam int TB_MAX_HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic        arb_en;
  logic [63:0] req;
  logic        grant_valid;
  logic [5:0]  grant_idx;
  logic [63:0] grant_onehot;

  int checks = 0;
  int errors = 0;

  // Reference state: who holds the grant, who was served last, how long the holder has held.
  logic        m_valid;
  logic [5:0]  m_idx;
  int          m_last;
  int          m_age;

  rr_grant_sched64 #(
    .MAX_HOLD (TB_MAX_HOLD),
    .HOLD_W   (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (arb_en),
    .req          (req),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_next(input logic [63:0] v, input int last);
    for (int k = 1; k <= 64; k++) begin
      int j;
      j = (last + k) % 64;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 6'd0;
    m_last  = 63;
    m_age   = 0;
  endtask

  task automatic model_step(input logic en, input logic [63:0] r);
    logic [63:0] others;
    logic        forced;
`ifdef HOLD_LIMIT_EN
    forced = r[m_idx] && (m_age == TB_MAX_HOLD - 1);
`else
    forced = 1'b0;
`endif
    if (!m_valid) begin
      if (en && (r != 64'd0)) begin
        m_idx   = 6'(find_next(r, m_last));
        m_valid = 1'b1;
        m_age   = 0;
      end
    end else if (r[m_idx] && !forced) begin
      m_age++;
    end else begin
      others        = r;
      others[m_idx] = 1'b0;
      m_last        = int'(m_idx);
      if (en && (others != 64'd0)) begin
        m_idx = 6'(find_next(others, m_last));
        m_age = 0;
      end else if (en && forced) begin
        m_age = 0;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_out(input string tag);
    logic [63:0] exp_oh;
    exp_oh = m_valid ? (64'd1 << m_idx) : 64'd0;
    checks++;
    assert (grant_valid === m_valid) else begin
      errors++;
      $error("FAIL %s grant_valid got %0b want %0b", tag, grant_valid, m_valid);
    end
    checks++;
    assert (grant_idx === m_idx) else begin
      errors++;
      $error("FAIL %s grant_idx got %0d want %0d", tag, grant_idx, m_idx);
    end
    checks++;
    assert (grant_onehot === exp_oh) else begin
      errors++;
      $error("FAIL %s grant_onehot got %h want %h", tag, grant_onehot, exp_oh);
    end
  endtask

  task automatic chk_idx(input string tag, input logic v, input int exp);
    checks++;
    assert ((grant_valid === v) && (!v || (grant_idx === 6'(exp)))) else begin
      errors++;
      $error("FAIL %s valid/idx got %0b/%0d want %0b/%0d", tag, grant_valid, grant_idx, v, exp);
    end
  endtask

  // Drive after a falling edge, let one rising edge happen, compare 1 time unit later.
  task automatic step(input logic en, input logic [63:0] r, input string tag);
    arb_en = en;
    req    = r;
    @(posedge clk);
    model_step(en, r);
    #1;
    check_out(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] r;
    logic        en;
    int          exp_i;

    rst_n  = 1'b0;
    arb_en = 1'b0;
    req    = 64'd0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single requester 0
    step(1'b1, 64'h1, "req0_grant");
    chk_idx("req0_idx", 1'b1, 0);
    step(1'b1, 64'h0, "req0_drop");
    chk_idx("req0_idle", 1'b0, 0);

    // 3, 10, 63 served back-to-back, each dropped two cycles after its grant
    r = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63);
    step(1'b1, r, "b2b_g3");        chk_idx("b2b_3", 1'b1, 3);
    step(1'b1, r, "b2b_h3");
    r[3] = 1'b0;
    step(1'b1, r, "b2b_g10");       chk_idx("b2b_10", 1'b1, 10);
    step(1'b1, r, "b2b_h10");
    r[10] = 1'b0;
    step(1'b1, r, "b2b_g63");       chk_idx("b2b_63", 1'b1, 63);
    step(1'b1, r, "b2b_h63");
    r[63] = 1'b0;
    step(1'b1, r, "b2b_idle");      chk_idx("b2b_end", 1'b0, 0);

    // Wrap-around: 62 released while 1 and 63 pend
    step(1'b1, 64'd1 << 62, "wrap_g62");
    chk_idx("wrap_62", 1'b1, 62);
    r = (64'd1 << 1) | (64'd1 << 63);
    step(1'b1, r, "wrap_g63");      chk_idx("wrap_63", 1'b1, 63);
    step(1'b1, 64'd1 << 1, "wrap_g1");
    chk_idx("wrap_1", 1'b1, 1);
    step(1'b1, 64'd0, "wrap_idle");

    // arb_en low blocks the regrant; 7 served once re-enabled
    step(1'b1, 64'd1 << 5, "en_g5");
    chk_idx("en_5", 1'b1, 5);
    step(1'b0, (64'd1 << 5) | (64'd1 << 7), "en_hold5");
    chk_idx("en_hold", 1'b1, 5);
    step(1'b0, 64'd1 << 7, "en_rel");
    chk_idx("en_idle", 1'b0, 0);
    step(1'b1, 64'd1 << 7, "en_g7");
    chk_idx("en_7", 1'b1, 7);
    step(1'b1, 64'd0, "en_idle2");

    // Continuous requesters 2 and 9 from a fresh pointer
    do_reset();
    r = (64'd1 << 2) | (64'd1 << 9);
    for (int k = 0; k < 12; k++) begin
`ifdef HOLD_LIMIT_EN
      exp_i = (((k / TB_MAX_HOLD) % 2) == 0) ? 2 : 9;
`else
      exp_i = 2;
`endif
      step(1'b1, r, "hold");
      chk_idx("hold_idx", 1'b1, exp_i);
    end
    step(1'b1, 64'd0, "hold_idle");

    // Asynchronous reset in the middle of grant 40
    step(1'b1, 64'd1 << 40, "ar_g40");
    chk_idx("ar_40", 1'b1, 40);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'd1 << 40, "ar_regrant");
    chk_idx("ar_40b", 1'b1, 40);
    step(1'b1, 64'd0, "ar_idle");

    // Randomized traffic
    r = 64'd0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r[$urandom_range(0, 63)] = 1'b1;
        4, 5:       r[$urandom_range(0, 63)] = 1'b0;
        6, 7:       if (m_valid) r[m_idx] = 1'b0;
        8:          if ($urandom_range(0, 3) == 0) r = 64'd0;
        default:    ;
      endcase
      en = ($urandom_range(0, 7) != 0);
      step(en, r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_grant_sched64

`default_nettype wire
